// File: rtl/alu_cmd_sequencer_if.sv
// Command/response handshake bundle between the issue logic (master) and alu_cmd_sequencer (slave).
interface alu_cmd_sequencer_if #(
  parameter int TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_a;
  logic [31:0]      cmd_b;
  logic [3:0]       cmd_opcode;
  logic [5:0]       cmd_shift;
  logic [TAG_W-1:0] cmd_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [63:0]      rsp_data;
  logic             rsp_carry;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_opcode, cmd_shift, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_tag, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_opcode, cmd_shift, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_tag, rsp_err
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Single-outstanding ALU initiator: registers a command onto the ALU, waits a per-opcode settle time, returns the result.
// Optional: define ALU_SEQ_DIV0_CHECK_EN to reject DIV with a zero divisor like an illegal opcode.
//
// state  | meaning
// S_IDLE | ready for a command, alu_* hold the last issued operation
// S_WAIT | ALU inputs applied, settle counter running down to terminal count 1
// S_RESP | response presented, held until rsp_ready
module alu_cmd_sequencer #(
  parameter int WAIT_SIMPLE = 1,
  parameter int WAIT_MUL    = 2,
  parameter int WAIT_DIV    = 4,
  parameter int TAG_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_cmd_sequencer_if.slave   bus,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [3:0]           alu_opcode,
  output logic [5:0]           alu_shift,
  input  logic [63:0]          alu_out,
  input  logic                 alu_carry,
  output logic                 busy,
  output logic [15:0]          ops_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       settle_cnt;
  logic [3:0]       settle_load;
  logic             reject;
  logic [TAG_W-1:0] tag_q;

  assign bus.rsp_tag = tag_q;

  always_comb begin
    settle_load = 4'(WAIT_SIMPLE);
    case (bus.cmd_opcode)
      4'd2:    settle_load = 4'(WAIT_MUL);
      4'd3:    settle_load = 4'(WAIT_DIV);
      default: settle_load = 4'(WAIT_SIMPLE);
    endcase
  end

`ifdef ALU_SEQ_DIV0_CHECK_EN
  assign reject = bus.cmd_opcode[3] ||
                  ((bus.cmd_opcode == 4'd3) && (bus.cmd_b == 32'd0));
`else
  assign reject = bus.cmd_opcode[3];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      settle_cnt    <= 4'd0;
      bus.cmd_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= 64'd0;
      bus.rsp_carry <= 1'b0;
      bus.rsp_err   <= 1'b0;
      tag_q         <= '0;
      alu_a         <= 32'd0;
      alu_b         <= 32'd0;
      alu_opcode    <= 4'd0;
      alu_shift     <= 6'd0;
      busy          <= 1'b0;
      ops_done      <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            tag_q         <= bus.cmd_tag;
            bus.cmd_ready <= 1'b0;
            busy          <= 1'b1;
            if (reject) begin
              // Rejected commands never touch the ALU inputs.
              bus.rsp_err   <= 1'b1;
              bus.rsp_data  <= 64'd0;
              bus.rsp_carry <= 1'b0;
              bus.rsp_valid <= 1'b1;
              state         <= S_RESP;
            end else begin
              alu_a      <= bus.cmd_a;
              alu_b      <= bus.cmd_b;
              alu_opcode <= bus.cmd_opcode;
              alu_shift  <= bus.cmd_shift;
              settle_cnt <= settle_load;
              state      <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (settle_cnt == 4'd1) begin
            bus.rsp_data  <= alu_out;
            bus.rsp_carry <= alu_carry;
            bus.rsp_err   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            state         <= S_RESP;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end

        S_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            busy          <= 1'b0;
            ops_done      <= ops_done + 16'd1;
            state         <= S_IDLE;
          end
        end

        default: begin
          state         <= S_IDLE;
          bus.rsp_valid <= 1'b0;
          bus.cmd_ready <= 1'b1;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU model; honours ALU_SEQ_DIV0_CHECK_EN.
module tb_alu_cmd_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_opcode;
  logic [5:0]  alu_shift;
  logic [63:0] alu_out;
  logic        alu_carry;
  logic        busy;
  logic [15:0] ops_done;
  logic [32:0] sum33;
  logic [63:0] held_data;

  int total  = 0;
  int passes = 0;

  alu_cmd_sequencer_if #(.TAG_W(4)) bus ();

  alu_cmd_sequencer #(
    .WAIT_SIMPLE(1), .WAIT_MUL(2), .WAIT_DIV(4), .TAG_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_shift(alu_shift),
    .alu_out(alu_out), .alu_carry(alu_carry), .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: ADD/SUB give 33-bit results, DIV packs {remainder, quotient}.
  always_comb begin
    sum33     = 33'd0;
    alu_out   = 64'd0;
    alu_carry = 1'b0;
    case (alu_opcode)
      4'd0: begin
        sum33 = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out = {31'd0, sum33};
        alu_carry = sum33[32];
      end
      4'd1: begin
        sum33 = {1'b0, alu_a} - {1'b0, alu_b};
        alu_out = {31'd0, sum33};
        alu_carry = sum33[32];
      end
      4'd2: alu_out = {32'd0, alu_a} * {32'd0, alu_b};
      4'd3: begin
        if (alu_b == 32'd0) begin
          alu_out = '1;
          alu_carry = 1'b1;
        end else begin
          alu_out = {alu_a % alu_b, alu_a / alu_b};
        end
      end
      default: alu_out = {32'd0, alu_a << alu_shift};
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       input logic [5:0] sh, input logic [3:0] tag);
    bus.cmd_a      = a;
    bus.cmd_b      = b;
    bus.cmd_opcode = op;
    bus.cmd_shift  = sh;
    bus.cmd_tag    = tag;
    bus.cmd_valid  = 1'b1;
    chk("accept_ready", 64'(bus.cmd_ready), 64'd1);
    tick();
    bus.cmd_valid  = 1'b0;
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_a      = 32'd0;
    bus.cmd_b      = 32'd0;
    bus.cmd_opcode = 4'd0;
    bus.cmd_shift  = 6'd0;
    bus.cmd_tag    = 4'd0;
    bus.rsp_ready  = 1'b0;

    // Reset / idle
    #23 rst_n = 1'b1;
    tick();
    tick();
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ops_done", 64'(ops_done), 64'd0);
    chk("rst_alu", {alu_a, alu_b} | 64'(alu_opcode) | 64'(alu_shift), 64'd0);
    chk("rst_rsp", bus.rsp_data | 64'(bus.rsp_tag) | 64'(bus.rsp_err) | 64'(bus.rsp_carry), 64'd0);

    // ADD with carry out, W=1
    issue(32'hFFFF_FFFF, 32'd1, 4'd0, 6'd0, 4'd3);
    chk("add_alu_a", 64'(alu_a), 64'hFFFF_FFFF);
    chk("add_busy", 64'(busy), 64'd1);
    chk("add_ready_low", 64'(bus.cmd_ready), 64'd0);
    chk("add_not_yet", 64'(bus.rsp_valid), 64'd0);
    bus.rsp_ready = 1'b1;
    tick();
    chk("add_valid", 64'(bus.rsp_valid), 64'd1);
    chk("add_data", bus.rsp_data, 64'h0000_0001_0000_0000);
    chk("add_carry", 64'(bus.rsp_carry), 64'd1);
    chk("add_tag", 64'(bus.rsp_tag), 64'd3);
    chk("add_err", 64'(bus.rsp_err), 64'd0);
    tick();
    chk("add_handoff", 64'(bus.rsp_valid), 64'd0);
    chk("add_ops", 64'(ops_done), 64'd1);
    chk("add_idle_ready", 64'(bus.cmd_ready), 64'd1);

    // MUL latency W=2
    issue(32'd7, 32'd6, 4'd2, 6'd0, 4'd5);
    chk("mul_n0", 64'(bus.rsp_valid), 64'd0);
    tick();
    chk("mul_n1", 64'(bus.rsp_valid), 64'd0);
    tick();
    chk("mul_valid", 64'(bus.rsp_valid), 64'd1);
    chk("mul_data", bus.rsp_data, 64'd42);
    chk("mul_tag", 64'(bus.rsp_tag), 64'd5);
    tick();
    chk("mul_ops", 64'(ops_done), 64'd2);

    // DIV W=4 under backpressure
    bus.rsp_ready = 1'b0;
    issue(32'd100, 32'd7, 4'd3, 6'd0, 4'd4);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("div_early", 64'(bus.rsp_valid), 64'd0);
    end
    tick();
    chk("div_valid", 64'(bus.rsp_valid), 64'd1);
    chk("div_data", bus.rsp_data, 64'h0000_0002_0000_000E);
    held_data = bus.rsp_data;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("bp_data", bus.rsp_data, 64'h0000_0002_0000_000E);
      chk("bp_ready_low", 64'(bus.cmd_ready), 64'd0);
    end
    chk("bp_tag", 64'(bus.rsp_tag), 64'd4);
    chk("bp_ops_held", 64'(ops_done), 64'd2);
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_release", 64'(bus.rsp_valid), 64'd0);
    chk("bp_ops", 64'(ops_done), 64'd3);

    // Illegal opcode: 1-cycle turnaround, ALU inputs untouched
    issue(32'h1234, 32'h5678, 4'd9, 6'd0, 4'd6);
    chk("ill_valid", 64'(bus.rsp_valid), 64'd1);
    chk("ill_err", 64'(bus.rsp_err), 64'd1);
    chk("ill_data", bus.rsp_data, 64'd0);
    chk("ill_carry", 64'(bus.rsp_carry), 64'd0);
    chk("ill_tag", 64'(bus.rsp_tag), 64'd6);
    chk("ill_alu_opcode", 64'(alu_opcode), 64'd3);
    chk("ill_alu_a", 64'(alu_a), 64'd100);
    tick();
    chk("ill_ops", 64'(ops_done), 64'd4);

    // DIV by zero
    issue(32'd5, 32'd0, 4'd3, 6'd0, 4'd8);
`ifdef ALU_SEQ_DIV0_CHECK_EN
    chk("div0_valid", 64'(bus.rsp_valid), 64'd1);
    chk("div0_err", 64'(bus.rsp_err), 64'd1);
    chk("div0_data", bus.rsp_data, 64'd0);
    chk("div0_alu_a", 64'(alu_a), 64'd100);
`else
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("div0_early", 64'(bus.rsp_valid), 64'd0);
    end
    tick();
    chk("div0_valid", 64'(bus.rsp_valid), 64'd1);
    chk("div0_err", 64'(bus.rsp_err), 64'd0);
    chk("div0_data", bus.rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("div0_carry", 64'(bus.rsp_carry), 64'd1);
`endif
    tick();
    chk("div0_ops", 64'(ops_done), 64'd5);

    // Back-to-back ADDs with cmd_valid held: second accept at N+W+2
    bus.cmd_a = 32'd10; bus.cmd_b = 32'd20; bus.cmd_opcode = 4'd0; bus.cmd_tag = 4'd2;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_a = 32'd4; bus.cmd_b = 32'd4; bus.cmd_tag = 4'd7;
    tick();
    chk("b2b_first", bus.rsp_data, 64'd30);
    chk("b2b_first_tag", 64'(bus.rsp_tag), 64'd2);
    tick();
    chk("b2b_gap_ready", 64'(bus.cmd_ready), 64'd1);
    chk("b2b_gap_alu_a", 64'(alu_a), 64'd10);
    tick();
    bus.cmd_valid = 1'b0;
    chk("b2b_second_alu_a", 64'(alu_a), 64'd4);
    chk("b2b_second_busy", 64'(busy), 64'd1);
    tick();
    chk("b2b_second_data", bus.rsp_data, 64'd8);
    chk("b2b_second_tag", 64'(bus.rsp_tag), 64'd7);
    tick();
    chk("b2b_ops", 64'(ops_done), 64'd7);

    // Reset during DIV wait: op dropped, counters return to reset values
    issue(32'd100, 32'd7, 4'd3, 6'd0, 4'd9);
    tick();
    rst_n = 1'b0;
    #2;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ready", 64'(bus.cmd_ready), 64'd1);
    #4 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end
    chk("midrst_ops", 64'(ops_done), 64'd0);
    chk("midrst_idle", 64'(busy), 64'd0);
    issue(32'd2, 32'd3, 4'd0, 6'd0, 4'd1);
    tick();
    chk("post_rst_valid", 64'(bus.rsp_valid), 64'd1);
    chk("post_rst_data", bus.rsp_data, 64'd5);
    chk("post_rst_tag", 64'(bus.rsp_tag), 64'd1);
    tick();
    chk("post_rst_ops", 64'(ops_done), 64'd1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
